// File: rtl/msg_seq_pkg.sv
// msg_seq_pkg: shared state encoding and mode constants for message_sequencer
package msg_seq_pkg;
    typedef enum logic [1:0] {MS_IDLE, MS_SEND, MS_GAP} ms_state_t;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_REPEAT  = 1'b1;
endpackage

// File: rtl/msg_buffer.sv
// msg_buffer: MSG_LEN x CHAR_W message storage, writable when MSG_SEQ_LOAD_EN is defined
module msg_buffer #(
    parameter int MSG_LEN = 12,
    parameter int CHAR_W  = 8,
    parameter logic [MSG_LEN*CHAR_W-1:0] MSG_INIT = "hello world!"
) (
`ifdef MSG_SEQ_LOAD_EN
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        wr_en,
    input  logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]                           wr_data,
`endif
    input  logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] rd_idx,
    output logic [CHAR_W-1:0]                           rd_data
);
    logic [CHAR_W-1:0] mem [MSG_LEN];
`ifdef MSG_SEQ_LOAD_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < MSG_LEN; i++)
                mem[i] <= MSG_INIT[(MSG_LEN-1-i)*CHAR_W +: CHAR_W];
        else if (wr_en && 32'(wr_addr) < MSG_LEN)
            mem[wr_addr] <= wr_data;
`else
    always_comb
        for (int i = 0; i < MSG_LEN; i++)
            mem[i] = MSG_INIT[(MSG_LEN-1-i)*CHAR_W +: CHAR_W];
`endif
    assign rd_data = mem[rd_idx];
endmodule

// File: rtl/message_sequencer.sv
// message_sequencer: valid/ready character source, one-shot or repeating with idle gap.
// Optional MSG_SEQ_LOAD_EN adds a runtime write port to the message storage.
module message_sequencer
    import msg_seq_pkg::*;
#(
    parameter int MSG_LEN    = 12,
    parameter int CHAR_W     = 8,
    parameter int GAP_CYCLES = 15000,
    parameter logic [MSG_LEN*CHAR_W-1:0] MSG_INIT = "hello world!"
) (
    input  logic                                        clk,
    input  logic                                        rst,
`ifdef MSG_SEQ_LOAD_EN
    input  logic                                        wr_en,
    input  logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]                           wr_data,
`endif
    input  logic                                        en,
    input  logic                                        mode,
    input  logic                                        start,
    input  logic                                        tx_ready,
    output logic                                        tx_valid,
    output logic [CHAR_W-1:0]                           tx_data,
    output logic                                        busy,
    output logic                                        msg_done,
    output logic [((MSG_LEN > 1) ? $clog2(MSG_LEN) : 1)-1:0] char_idx
);
    localparam int IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int CNT_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    ms_state_t         state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              done_d, xfer, load;
    logic [CHAR_W-1:0] rd_data;

    assign xfer     = (state == MS_SEND) && tx_ready;
    assign tx_valid = (state == MS_SEND);
    assign busy     = (state != MS_IDLE);
    assign char_idx = idx;

    msg_buffer #(.MSG_LEN(MSG_LEN), .CHAR_W(CHAR_W), .MSG_INIT(MSG_INIT)) u_buf (
`ifdef MSG_SEQ_LOAD_EN
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
`endif
        .rd_idx(idx_d),
        .rd_data(rd_data)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        done_d  = 1'b0;
        if (!en) begin
            state_d = MS_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                MS_IDLE: state_d = start ? MS_SEND : MS_IDLE;
                MS_SEND: if (xfer) begin
                    if (idx == IDX_W'(MSG_LEN - 1)) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = (mode == MODE_REPEAT) ? ((GAP_CYCLES > 0) ? MS_GAP : MS_SEND) : MS_IDLE;
                    end else
                        idx_d = idx + IDX_W'(1);
                end
                MS_GAP: begin
                    state_d = (cnt == CNT_W'(GAP_LAST)) ? MS_SEND : MS_GAP;
                    cnt_d   = (cnt == CNT_W'(GAP_LAST)) ? '0 : cnt + CNT_W'(1);
                end
                default: state_d = MS_IDLE;
            endcase
        end
    end

    // tx_data is captured only when a new character is presented, so it holds while stalled
    assign load = (state_d == MS_SEND) && ((state != MS_SEND) || xfer);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= MS_IDLE;
            idx      <= '0;
            cnt      <= '0;
            msg_done <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            cnt      <= cnt_d;
            msg_done <= done_d;
            if (load)
                tx_data <= rd_data;
        end
endmodule

// File: tb/tb_message_sequencer.sv
// tb_message_sequencer: random stimulus vs behavioural model, instances with GAP_CYCLES 5 and 0
module tb_message_sequencer;
    logic clk = 1'b0;
    logic rst, en, mode, start, tx_ready;
    logic       v0, v1, b0, b1, dn0, dn1;
    logic [7:0] d0, d1;
    logic [3:0] ci0, ci1;
`ifdef MSG_SEQ_LOAD_EN
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    message_sequencer #(.GAP_CYCLES(5)) u_g5 (
        .clk(clk), .rst(rst),
`ifdef MSG_SEQ_LOAD_EN
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
        .en(en), .mode(mode), .start(start), .tx_ready(tx_ready),
        .tx_valid(v0), .tx_data(d0), .busy(b0), .msg_done(dn0), .char_idx(ci0));

    message_sequencer #(.GAP_CYCLES(0)) u_g0 (
        .clk(clk), .rst(rst),
`ifdef MSG_SEQ_LOAD_EN
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`endif
        .en(en), .mode(mode), .start(start), .tx_ready(tx_ready),
        .tx_valid(v1), .tx_data(d1), .busy(b1), .msg_done(dn1), .char_idx(ci1));

    // Model: phase 0 idle, 1 sending, 2 gap; gl counts remaining gap cycles
    int         ph[2], pos[2], gl[2];
    int         gcyc[2] = '{5, 0};
    logic       dm[2];
    logic [7:0] cur[2];
    logic [7:0] msg[2][12];
    logic [95:0] init_msg = "hello world!";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_zero();
        check("rst_valid0", 32'(v0), 0);  check("rst_data0", 32'(d0), 0);
        check("rst_busy0", 32'(b0), 0);   check("rst_done0", 32'(dn0), 0);
        check("rst_idx0", 32'(ci0), 0);   check("rst_valid1", 32'(v1), 0);
        check("rst_data1", 32'(d1), 0);   check("rst_busy1", 32'(b1), 0);
        check("rst_done1", 32'(dn1), 0);  check("rst_idx1", 32'(ci1), 0);
    endtask

    task automatic check_inst(input int k, input logic v, input logic [7:0] d, input logic b,
                              input logic dn, input logic [3:0] ci);
        check($sformatf("valid%0d", k), 32'(v), 32'(ph[k] == 1));
        check($sformatf("busy%0d", k), 32'(b), 32'(ph[k] != 0));
        check($sformatf("done%0d", k), 32'(dn), 32'(dm[k]));
        check($sformatf("idx%0d", k), 32'(ci), 32'(pos[k]));
        if (ph[k] == 1)
            check($sformatf("data%0d", k), 32'(d), 32'(cur[k]));
    endtask

    always @(posedge clk or posedge rst) begin
        logic x;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                ph[k] = 0; pos[k] = 0; gl[k] = 0; dm[k] = 0; cur[k] = 0;
                for (int i = 0; i < 12; i++) msg[k][i] = init_msg[(11-i)*8 +: 8];
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                x = (ph[k] == 1) && tx_ready;
                dm[k] = 0;
                if (!en) begin
                    ph[k] = 0; pos[k] = 0;
                end else if (ph[k] == 0) begin
                    if (start) begin ph[k] = 1; pos[k] = 0; cur[k] = msg[k][0]; end
                end else if (ph[k] == 1) begin
                    if (x && pos[k] == 11) begin
                        dm[k] = 1; pos[k] = 0;
                        if (!mode) ph[k] = 0;
                        else if (gcyc[k] > 0) begin ph[k] = 2; gl[k] = gcyc[k]; end
                        else cur[k] = msg[k][0];
                    end else if (x) begin
                        pos[k]++; cur[k] = msg[k][pos[k]];
                    end
                end else begin
                    gl[k]--;
                    if (gl[k] == 0) begin ph[k] = 1; cur[k] = msg[k][0]; end
                end
`ifdef MSG_SEQ_LOAD_EN
                if (wr_en && wr_addr < 12) msg[k][wr_addr] = wr_data;
`endif
            end
        end
    end

    always @(negedge clk)
        if (!rst) begin
            check_inst(0, v0, d0, b0, dn0, ci0);
            check_inst(1, v1, d1, b1, dn1, ci1);
        end

    initial begin
        int n;
        rst = 1; en = 0; mode = 0; start = 0; tx_ready = 0;
`ifdef MSG_SEQ_LOAD_EN
        wr_en = 0; wr_addr = 0; wr_data = 0;
`endif
        #1 check_zero();
        repeat (2) @(negedge clk);
        rst = 0;
        @(negedge clk); en = 1; start = 1; tx_ready = 1;
        @(negedge clk); start = 0;
        repeat (20) @(negedge clk);
        mode = 1; start = 1;
        @(negedge clk); start = 0;
        repeat (45) @(negedge clk);
        repeat (60) begin tx_ready = ($urandom_range(0, 2) == 0); @(negedge clk); end
        // abandon a pass at index 4 with no transfer pending
        mode = 0; en = 0;
        @(negedge clk); en = 1; start = 1; tx_ready = 1;
        n = 0;
        do begin @(negedge clk); start = 0; n++; end while (pos[0] != 4 && n < 20);
        check("reach_idx4", 32'(pos[0]), 4);
        tx_ready = 0; en = 0;
        repeat (2) @(negedge clk);
        // asynchronous reset while in the gap
        en = 1; mode = 1; start = 1; tx_ready = 1;
        n = 0;
        do begin @(negedge clk); start = 0; n++; end while (ph[0] != 2 && n < 40);
        check("reach_gap", 32'(ph[0]), 2);
        #2 rst = 1;
        #1 check_zero();
        @(negedge clk); rst = 0;
        repeat (3) @(negedge clk);
        repeat (600) begin
            en       = ($urandom_range(0, 39) != 0);
            mode     = 1'($urandom);
            start    = ($urandom_range(0, 3) == 0);
            tx_ready = 1'($urandom);
`ifdef MSG_SEQ_LOAD_EN
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_addr  = 4'($urandom);
            wr_data  = 8'($urandom);
`endif
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
